// File: rtl/alu_div8_pkg.sv
// Shared ALU definitions: datapath width and divider FSM state encoding.
package alu_div8_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/alu_div8_div_step.sv
// One restoring-division step: trial subtract, carry=1 when a_i >= b_i.
module div_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         carry_o
);

    logic borrow;

    // Extra MSB captures the borrow; carry is its inverse, as in SBC.
    assign {borrow, diff_o} = {1'b0, a_i} - {1'b0, b_i};
    assign carry_o = ~borrow;

endmodule

// File: rtl/alu_div8.sv
// Unsigned restoring divider, one quotient bit per cycle, fixed latency.
module alu_div8
    import alu_div8_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             unused_msb;

    // Partial remainder widened by one bit before the trial subtract.
    assign shifted = {prem_q, dvd_q[WIDTH-1]};

    div_step #(
        .W(WIDTH + 1)
    ) u_step (
        .a_i    (shifted),
        .b_i    ({1'b0, dvs_q}),
        .diff_o (diff),
        .carry_o(carry)
    );

    // After a successful subtract the difference is below the divisor.
    assign unused_msb = diff[WIDTH];
    assign step_rem = carry ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {dvd_q[WIDTH-2:0], carry};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = divisor;
                    dvd_d  = dividend;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step_rem;
                dvd_d  = step_quo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    quo_d   = step_quo;
                    rem_d   = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_alu_div8.sv
// Directed and sampled-sweep checks for the alu_div8 restoring divider.
module tb_alu_div8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_div8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic run(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic edbz,
                       input bit poke);
        int lat = 0;
        int bsy = 0;
        int moved = 0;
        logic [7:0] q0, r0;
        @(negedge clk);
        q0 = quotient;
        r0 = remainder;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (poke) begin
            dividend = 8'd9;
            divisor = 8'd3;
        end else begin
            start = 1'b0;
            dividend = 8'($urandom);
            divisor = 8'($urandom);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) bsy++;
            if (quotient != q0 || remainder != r0) moved++;
        end
        start = 1'b0;
        check({tag, ":lat"}, lat, (b == 0) ? 1 : 9);
        check({tag, ":busy"}, bsy, (b == 0) ? 0 : 8);
        check({tag, ":hold"}, moved, 0);
        check({tag, ":q"}, quotient, eq);
        check({tag, ":r"}, remainder, er);
        check({tag, ":dbz"}, div_by_zero, edbz);
        if (poke) count_done({tag, ":extra_done"}, 12);
    endtask

    initial begin
        logic [7:0] a, b;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:q", quotient, 0);
        check("rst:r", remainder, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:dbz", div_by_zero, 0);
        rst = 1'b0;

        run("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        run("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        run("3/200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 1'b0);
        run("5/0", 8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1'b0);
        run("poke", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
        run("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
        run("0/9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0);
        run("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 1'b0);
        run("0/0", 8'd0, 8'd0, 8'd255, 8'd0, 1'b1, 1'b0);
        run("128/2", 8'd128, 8'd2, 8'd64, 8'd0, 1'b0, 1'b0);

        // Abort a division on its fourth CALC cycle.
        @(negedge clk);
        dividend = 8'd100;
        divisor = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort:q", quotient, 0);
        check("abort:r", remainder, 0);
        check("abort:busy", busy, 0);
        check("abort:done", done, 0);
        check("abort:dbz", div_by_zero, 0);
        count_done("abort:no_done", 12);
        run("200/13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b0);

        // start coinciding with reset must not launch a division.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        dividend = 8'd10;
        divisor = 8'd2;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rststart:busy", busy, 0);
        check("rststart:q", quotient, 0);
        count_done("rststart:no_done", 10);

        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 50 == 0) b = 8'd0;
            if (b == 0)
                run("rnd", a, b, 8'd255, a, 1'b1, 1'b0);
            else
                run("rnd", a, b, a / b, a % b, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
